// File: rtl/core101_issue_pkg.sv
// Shared constants for the issue stage: execution-unit one-hot selects and field widths.
package core101_issue_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int UOP_W           = 4;
  localparam int MAX_OUTSTANDING = 4;

  localparam logic [2:0] INT_EXEC_SEL = 3'b001;
  localparam logic [2:0] LSU_EXEC_SEL = 3'b010;
  localparam logic [2:0] VEC_EXEC_SEL = 3'b100;

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel == INT_EXEC_SEL) || (sel == LSU_EXEC_SEL) || (sel == VEC_EXEC_SEL);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard for destinations owned by the multi-cycle units.
// Register 0 is architecturally constant, so its bit never becomes busy.
module issue_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clock_in,
  input  logic              i_clear,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_rd_busy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clear is applied before set so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock_in) begin
    if (i_clear) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];
  assign o_rd_busy  = r_busy[i_rd_addr];

endmodule

// File: rtl/issue_controller.sv
// One-entry issue stage: holds a decoded instruction, checks hazards and per-unit
// outstanding limits, and issues it to INT/LSU/VEC over valid/ready.
module issue_controller #(
  parameter int REG_ADDR_W      = core101_issue_pkg::REG_ADDR_W,
  parameter int UOP_W           = core101_issue_pkg::UOP_W,
  parameter int MAX_OUTSTANDING = core101_issue_pkg::MAX_OUTSTANDING
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  dec_valid_in,
  output logic                  dec_ready_out,
  input  logic [2:0]            dec_sel_in,
  input  logic [UOP_W-1:0]      dec_uop_in,
  input  logic [REG_ADDR_W-1:0] dec_rs1_in,
  input  logic [REG_ADDR_W-1:0] dec_rs2_in,
  input  logic [REG_ADDR_W-1:0] dec_rd_in,
  input  logic                  dec_rd_we_in,
  input  logic                  dec_pc_mux_sel_in,
  input  logic                  dec_imm_mux_sel_in,
  output logic                  int_valid_out,
  input  logic                  int_ready_in,
  output logic                  lsu_valid_out,
  input  logic                  lsu_ready_in,
  output logic                  vec_valid_out,
  input  logic                  vec_ready_in,
  output logic [UOP_W-1:0]      iss_uop_out,
  output logic [REG_ADDR_W-1:0] iss_rd_out,
  output logic                  iss_pc_mux_sel_out,
  output logic                  iss_imm_mux_sel_out,
  input  logic                  lsu_done_in,
  input  logic                  vec_done_in,
  input  logic                  wb_valid_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_in,
  output logic                  invalid_ins_out
);

  import core101_issue_pkg::*;

  // Handshake: a unit's valid, once raised, stays high with a stable payload until
  // that unit's ready is sampled high at a rising edge; only flush or reset withdraws it.
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                  r_hold_valid;
  logic [2:0]            r_hold_sel;
  logic [UOP_W-1:0]      r_hold_uop;
  logic [REG_ADDR_W-1:0] r_hold_rs1;
  logic [REG_ADDR_W-1:0] r_hold_rs2;
  logic [REG_ADDR_W-1:0] r_hold_rd;
  logic                  r_hold_rd_we;
  logic                  r_hold_pc_sel;
  logic                  r_hold_imm_sel;
  logic [CNT_W-1:0]      r_cnt_lsu;
  logic [CNT_W-1:0]      r_cnt_vec;

  logic w_kill;
  logic w_is_int, w_is_lsu, w_is_vec, w_bad;
  logic w_rs1_busy, w_rs2_busy, w_rd_busy, w_hazard;
  logic w_int_valid, w_lsu_valid, w_vec_valid;
  logic w_fire_int, w_fire_lsu, w_fire_vec, w_fire;
  logic w_drop, w_dec_ready, w_accept;
  logic w_lsu_ret, w_vec_ret;
  logic w_sb_set;

  assign w_kill   = reset_in | flush_in;
  assign w_is_int = r_hold_valid && (r_hold_sel == INT_EXEC_SEL);
  assign w_is_lsu = r_hold_valid && (r_hold_sel == LSU_EXEC_SEL);
  assign w_is_vec = r_hold_valid && (r_hold_sel == VEC_EXEC_SEL);
  assign w_bad    = r_hold_valid && !sel_is_legal(r_hold_sel);

  issue_scoreboard #(.ADDR_W(REG_ADDR_W)) u_scoreboard (
    .clock_in   (clock_in),
    .i_clear    (w_kill),
    .i_set_en   (w_sb_set),
    .i_set_addr (r_hold_rd),
    .i_clr_en   (wb_valid_in),
    .i_clr_addr (wb_rd_in),
    .i_rs1_addr (r_hold_rs1),
    .i_rs2_addr (r_hold_rs2),
    .i_rd_addr  (r_hold_rd),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy)
  );

  assign w_hazard = w_rs1_busy | w_rs2_busy | (r_hold_rd_we & w_rd_busy);

  assign w_int_valid = !w_kill && w_is_int && !w_hazard;
  assign w_lsu_valid = !w_kill && w_is_lsu && !w_hazard && (r_cnt_lsu < CNT_MAX);
  assign w_vec_valid = !w_kill && w_is_vec && !w_hazard && (r_cnt_vec < CNT_MAX);

  assign w_fire_int = w_int_valid && int_ready_in;
  assign w_fire_lsu = w_lsu_valid && lsu_ready_in;
  assign w_fire_vec = w_vec_valid && vec_ready_in;
  assign w_fire     = w_fire_int | w_fire_lsu | w_fire_vec;

  assign w_drop      = !w_kill && w_bad;
  assign w_dec_ready = !w_kill && (!r_hold_valid || w_fire || w_drop);
  assign w_accept    = dec_valid_in && w_dec_ready;

  // INT results are bypassed, so only the multi-cycle units claim a destination.
  assign w_sb_set = (w_fire_lsu | w_fire_vec) && r_hold_rd_we && (r_hold_rd != '0);

  assign w_lsu_ret = lsu_done_in && (r_cnt_lsu != '0);
  assign w_vec_ret = vec_done_in && (r_cnt_vec != '0);

  always_ff @(posedge clock_in) begin
    if (w_kill) begin
      r_hold_valid   <= 1'b0;
      r_hold_sel     <= '0;
      r_hold_uop     <= '0;
      r_hold_rs1     <= '0;
      r_hold_rs2     <= '0;
      r_hold_rd      <= '0;
      r_hold_rd_we   <= 1'b0;
      r_hold_pc_sel  <= 1'b0;
      r_hold_imm_sel <= 1'b0;
    end else if (w_accept) begin
      r_hold_valid   <= 1'b1;
      r_hold_sel     <= dec_sel_in;
      r_hold_uop     <= dec_uop_in;
      r_hold_rs1     <= dec_rs1_in;
      r_hold_rs2     <= dec_rs2_in;
      r_hold_rd      <= dec_rd_in;
      r_hold_rd_we   <= dec_rd_we_in;
      r_hold_pc_sel  <= dec_pc_mux_sel_in;
      r_hold_imm_sel <= dec_imm_mux_sel_in;
    end else if (w_fire || w_drop) begin
      r_hold_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_kill) begin
      r_cnt_lsu <= '0;
      r_cnt_vec <= '0;
    end else begin
      if (w_fire_lsu && !w_lsu_ret)      r_cnt_lsu <= r_cnt_lsu + CNT_ONE;
      else if (!w_fire_lsu && w_lsu_ret) r_cnt_lsu <= r_cnt_lsu - CNT_ONE;
      if (w_fire_vec && !w_vec_ret)      r_cnt_vec <= r_cnt_vec + CNT_ONE;
      else if (!w_fire_vec && w_vec_ret) r_cnt_vec <= r_cnt_vec - CNT_ONE;
    end
  end

  assign dec_ready_out       = w_dec_ready;
  assign int_valid_out       = w_int_valid;
  assign lsu_valid_out       = w_lsu_valid;
  assign vec_valid_out       = w_vec_valid;
  assign invalid_ins_out     = w_drop;
  assign iss_uop_out         = r_hold_valid ? r_hold_uop     : '0;
  assign iss_rd_out          = r_hold_valid ? r_hold_rd      : '0;
  assign iss_pc_mux_sel_out  = r_hold_valid ? r_hold_pc_sel  : 1'b0;
  assign iss_imm_mux_sel_out = r_hold_valid ? r_hold_imm_sel : 1'b0;

endmodule

// File: tb/tb_issue_controller.sv
// Directed bench for issue_controller: hand-computed expectations checked with
// immediate assertions one cycle at a time.
module tb_issue_controller;

  logic       clock_in = 1'b0;
  logic       reset_in, flush_in;
  logic       dec_valid_in, dec_ready_out;
  logic [2:0] dec_sel_in;
  logic [3:0] dec_uop_in;
  logic [4:0] dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic       dec_rd_we_in, dec_pc_mux_sel_in, dec_imm_mux_sel_in;
  logic       int_valid_out, int_ready_in;
  logic       lsu_valid_out, lsu_ready_in;
  logic       vec_valid_out, vec_ready_in;
  logic [3:0] iss_uop_out;
  logic [4:0] iss_rd_out;
  logic       iss_pc_mux_sel_out, iss_imm_mux_sel_out;
  logic       lsu_done_in, vec_done_in;
  logic       wb_valid_in;
  logic [4:0] wb_rd_in;
  logic       invalid_ins_out;

  int checks = 0;
  int errors = 0;

  issue_controller dut (
    .clock_in(clock_in), .reset_in(reset_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_sel_in(dec_sel_in), .dec_uop_in(dec_uop_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
    .dec_rd_we_in(dec_rd_we_in), .dec_pc_mux_sel_in(dec_pc_mux_sel_in),
    .dec_imm_mux_sel_in(dec_imm_mux_sel_in),
    .int_valid_out(int_valid_out), .int_ready_in(int_ready_in),
    .lsu_valid_out(lsu_valid_out), .lsu_ready_in(lsu_ready_in),
    .vec_valid_out(vec_valid_out), .vec_ready_in(vec_ready_in),
    .iss_uop_out(iss_uop_out), .iss_rd_out(iss_rd_out),
    .iss_pc_mux_sel_out(iss_pc_mux_sel_out), .iss_imm_mux_sel_out(iss_imm_mux_sel_out),
    .lsu_done_in(lsu_done_in), .vec_done_in(vec_done_in),
    .wb_valid_in(wb_valid_in), .wb_rd_in(wb_rd_in),
    .invalid_ins_out(invalid_ins_out)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [2:0] sel, input logic [3:0] uop, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                       input logic pc, input logic imm);
    dec_valid_in       = 1'b1;
    dec_sel_in         = sel;
    dec_uop_in         = uop;
    dec_rs1_in         = rs1;
    dec_rs2_in         = rs2;
    dec_rd_in          = rd;
    dec_rd_we_in       = we;
    dec_pc_mux_sel_in  = pc;
    dec_imm_mux_sel_in = imm;
  endtask

  task automatic idle();
    dec_valid_in = 1'b0;
    dec_sel_in   = 3'b000;
    dec_uop_in   = 4'h0;
    dec_rs1_in   = 5'd0;
    dec_rs2_in   = 5'd0;
    dec_rd_in    = 5'd0;
    dec_rd_we_in = 1'b0;
    dec_pc_mux_sel_in  = 1'b0;
    dec_imm_mux_sel_in = 1'b0;
  endtask

  task automatic chk_valids(input string tag, input logic i, input logic l, input logic v);
    chk({tag, "_int_valid"}, 32'(int_valid_out), 32'(i));
    chk({tag, "_lsu_valid"}, 32'(lsu_valid_out), 32'(l));
    chk({tag, "_vec_valid"}, 32'(vec_valid_out), 32'(v));
  endtask

  initial begin
    reset_in = 1'b1; flush_in = 1'b0;
    int_ready_in = 1'b1; lsu_ready_in = 1'b1; vec_ready_in = 1'b1;
    lsu_done_in = 1'b0; vec_done_in = 1'b0;
    wb_valid_in = 1'b0; wb_rd_in = 5'd0;
    idle();

    // Reset state
    tick(); tick();
    chk("rst_dec_ready", 32'(dec_ready_out), 32'd0);
    chk_valids("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_invalid", 32'(invalid_ins_out), 32'd0);
    reset_in = 1'b0;
    settle();
    chk("post_rst_dec_ready", 32'(dec_ready_out), 32'd1);
    chk("post_rst_uop", 32'(iss_uop_out), 32'd0);

    // Back-to-back INT ADDs at one per cycle
    offer(3'b001, 4'h0, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("int0_empty_valid", 32'(int_valid_out), 32'd0);
    tick();
    offer(3'b001, 4'h0, 5'd2, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0);
    settle();
    chk("int1_valid", 32'(int_valid_out), 32'd1);
    chk("int1_rd", 32'(iss_rd_out), 32'd1);
    chk("int1_dec_ready", 32'(dec_ready_out), 32'd1);
    tick();
    offer(3'b001, 4'h0, 5'd2, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1);
    settle();
    chk("int2_valid", 32'(int_valid_out), 32'd1);
    chk("int2_rd", 32'(iss_rd_out), 32'd2);
    chk("int2_pc", 32'(iss_pc_mux_sel_out), 32'd1);
    chk("int2_dec_ready", 32'(dec_ready_out), 32'd1);
    tick();
    idle();
    settle();
    chk("int3_valid", 32'(int_valid_out), 32'd1);
    chk("int3_rd", 32'(iss_rd_out), 32'd3);
    chk("int3_imm", 32'(iss_imm_mux_sel_out), 32'd1);
    tick();
    settle();
    chk("int_drain_valid", 32'(int_valid_out), 32'd0);
    chk("int_drain_rd", 32'(iss_rd_out), 32'd0);

    // LSU load rd=5 then dependent INT
    offer(3'b010, 4'h2, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    offer(3'b001, 4'h1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("lw_valid", 32'(lsu_valid_out), 32'd1);
    chk("lw_rd", 32'(iss_rd_out), 32'd5);
    chk("lw_uop", 32'(iss_uop_out), 32'd2);
    tick();
    idle();
    settle();
    chk_valids("raw_held0", 1'b0, 1'b0, 1'b0);
    chk("raw_dec_ready", 32'(dec_ready_out), 32'd0);
    chk("raw_rd", 32'(iss_rd_out), 32'd6);
    tick();
    wb_valid_in = 1'b1; wb_rd_in = 5'd5;
    settle();
    chk("raw_held_wb_cycle", 32'(int_valid_out), 32'd0);
    tick();
    wb_valid_in = 1'b0;
    settle();
    chk("raw_release", 32'(int_valid_out), 32'd1);
    tick();
    settle();
    chk("raw_issued", 32'(int_valid_out), 32'd0);
    chk("raw_dec_ready_after", 32'(dec_ready_out), 32'd1);
    lsu_done_in = 1'b1;
    tick();
    // Extra done pulse while the LSU counter is already 0
    tick();
    lsu_done_in = 1'b0;

    // Outstanding limit: five LSU ops, no done
    for (int k = 0; k < 5; k++) begin
      offer(3'b010, 4'(k + 8), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      settle();
      if (k > 0) chk($sformatf("lsu_lim_valid%0d", k), 32'(lsu_valid_out), 32'd1);
      tick();
    end
    idle();
    settle();
    chk("lsu_5th_blocked", 32'(lsu_valid_out), 32'd0);
    chk("lsu_5th_dec_ready", 32'(dec_ready_out), 32'd0);
    chk("lsu_5th_uop", 32'(iss_uop_out), 32'd12);
    tick();
    lsu_done_in = 1'b1;
    settle();
    chk("lsu_5th_done_cycle", 32'(lsu_valid_out), 32'd0);
    tick();
    lsu_done_in = 1'b0;
    settle();
    chk("lsu_5th_release", 32'(lsu_valid_out), 32'd1);
    tick();
    settle();
    chk("lsu_5th_gone", 32'(lsu_valid_out), 32'd0);

    // Invalid selections
    offer(3'b000, 4'h3, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    offer(3'b001, 4'h5, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("bad000_pulse", 32'(invalid_ins_out), 32'd1);
    chk_valids("bad000", 1'b0, 1'b0, 1'b0);
    chk("bad000_dec_ready", 32'(dec_ready_out), 32'd1);
    tick();
    offer(3'b011, 4'h4, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    settle();
    chk("bad000_pulse_end", 32'(invalid_ins_out), 32'd0);
    chk("after_bad_int_valid", 32'(int_valid_out), 32'd1);
    chk("after_bad_uop", 32'(iss_uop_out), 32'd5);
    tick();
    idle();
    settle();
    chk("bad011_pulse", 32'(invalid_ins_out), 32'd1);
    chk_valids("bad011", 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    chk("bad011_pulse_end", 32'(invalid_ins_out), 32'd0);
    chk("bad011_dropped", 32'(dec_ready_out), 32'd1);

    // VEC issue sets rd=12, then a stalled VEC op, then flush
    offer(3'b100, 4'h6, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    offer(3'b100, 4'h7, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0);
    settle();
    chk("vec1_valid", 32'(vec_valid_out), 32'd1);
    tick();
    idle();
    vec_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("vec_stall_valid%0d", k), 32'(vec_valid_out), 32'd1);
      chk($sformatf("vec_stall_uop%0d", k), 32'(iss_uop_out), 32'd7);
      chk($sformatf("vec_stall_rd%0d", k), 32'(iss_rd_out), 32'd10);
      chk($sformatf("vec_stall_pc%0d", k), 32'(iss_pc_mux_sel_out), 32'd1);
      chk($sformatf("vec_stall_ready%0d", k), 32'(dec_ready_out), 32'd0);
      tick();
    end
    flush_in = 1'b1;
    settle();
    chk_valids("flush", 1'b0, 1'b0, 1'b0);
    chk("flush_dec_ready", 32'(dec_ready_out), 32'd0);
    tick();
    flush_in = 1'b0;
    vec_ready_in = 1'b1;
    offer(3'b001, 4'h1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    settle();
    chk("post_flush_dec_ready", 32'(dec_ready_out), 32'd1);
    chk("post_flush_hold_empty", 32'(iss_uop_out), 32'd0);
    tick();
    offer(3'b010, 4'h2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("flush_cleared_sb", 32'(int_valid_out), 32'd1);
    tick();
    idle();
    settle();
    chk("flush_cleared_cnt", 32'(lsu_valid_out), 32'd1);
    tick();
    lsu_done_in = 1'b1;
    tick();
    lsu_done_in = 1'b0;

    // Same-cycle set and clear of rd=7: set wins
    offer(3'b010, 4'h2, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    wb_valid_in = 1'b1; wb_rd_in = 5'd7;
    settle();
    chk("sc_lsu_valid", 32'(lsu_valid_out), 32'd1);
    tick();
    wb_valid_in = 1'b0;
    offer(3'b001, 4'h1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("sc_bit7_set", 32'(int_valid_out), 32'd0);
    tick();
    wb_valid_in = 1'b1; wb_rd_in = 5'd7;
    tick();
    wb_valid_in = 1'b0;
    settle();
    chk("sc_bit7_cleared", 32'(int_valid_out), 32'd1);
    tick();

    // Register 0 never becomes busy
    offer(3'b010, 4'h2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    offer(3'b001, 4'h1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("r0_not_busy", 32'(int_valid_out), 32'd1);
    tick();

    // Reset in the middle of a stalled VEC op
    vec_ready_in = 1'b0;
    offer(3'b100, 4'h9, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("mid_vec_valid", 32'(vec_valid_out), 32'd1);
    reset_in = 1'b1;
    settle();
    chk_valids("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_dec_ready", 32'(dec_ready_out), 32'd0);
    tick();
    reset_in = 1'b0;
    vec_ready_in = 1'b1;
    settle();
    chk("mid_rst_after_valid", 32'(vec_valid_out), 32'd0);
    chk("mid_rst_after_ready", 32'(dec_ready_out), 32'd1);
    chk("mid_rst_after_uop", 32'(iss_uop_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
